// File: rtl/gray_digit_scanner.sv
// Gray-coded switch front end: synchronise, debounce, Gray->binary, BCD split,
// then time-multiplex tens/units digits onto one 7-segment decoder bus.
module gray_digit_scanner #(
  parameter int REFRESH_DIV   = 27000,
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] gray_in,
  output logic [3:0] binary_code,
  output logic [1:0] digit_en_n,
  output logic [3:0] bin_value,
  output logic       update_pulse
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] STB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {BLANK_U, SCAN_U, BLANK_T, SCAN_T} state_t;

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    cand_q, cand_d, gray_q, gray_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]    bin_q, bin_d, tens_q, tens_d, units_q, units_d;
  logic          upd_q, upd_d;
  state_t        state_q, state_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [3:0]    code_q, code_d;
  logic [1:0]    en_n_q, en_n_d;
  logic [3:0]    bin_new;

  // Gray decode is taken from the candidate, which equals sync2 whenever a commit fires.
  assign bin_new[3] = cand_q[3];
  genvar gi;
  generate
    for (gi = 2; gi >= 0; gi--) begin : g_gray2bin
      assign bin_new[gi] = bin_new[gi+1] ^ cand_q[gi];
    end
  endgenerate

  always_comb begin
    sync1_d    = gray_in;
    sync2_d    = sync1_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    gray_d     = gray_q;
    bin_d      = bin_q;
    tens_d     = tens_q;
    units_d    = units_q;
    upd_d      = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d     = sync2_q;
      stab_cnt_d = '0;
    end else begin
      if (stab_cnt_q != STB_MAX) begin
        stab_cnt_d = stab_cnt_q + 1'b1;
      end
      if ((stab_cnt_q == STB_MAX) && (cand_q != gray_q)) begin
        gray_d  = cand_q;
        bin_d   = bin_new;
        tens_d  = (bin_new >= 4'd10) ? 4'd1 : 4'd0;
        units_d = (bin_new >= 4'd10) ? (bin_new - 4'd10) : bin_new;
        upd_d   = 1'b1;
      end
    end
  end

  // Scan outputs are decoded from the current state, so they lag it by one edge.
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    en_n_d    = 2'b11;
    code_d    = 4'd0;
    case (state_q)
      BLANK_U: begin
        state_d   = SCAN_U;
        ref_cnt_d = '0;
      end
      SCAN_U: begin
        en_n_d = 2'b10;
        code_d = units_q;
        if (ref_cnt_q == REF_MAX) begin
          state_d   = BLANK_T;
          ref_cnt_d = '0;
        end else begin
          ref_cnt_d = ref_cnt_q + 1'b1;
        end
      end
      BLANK_T: begin
        state_d   = SCAN_T;
        ref_cnt_d = '0;
      end
      SCAN_T: begin
        if (tens_q != 4'd0) begin
          en_n_d = 2'b01;
          code_d = tens_q;
        end
        if (ref_cnt_q == REF_MAX) begin
          state_d   = BLANK_U;
          ref_cnt_d = '0;
        end else begin
          ref_cnt_d = ref_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = BLANK_U;
        ref_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'd0;
      sync2_q    <= 4'd0;
      cand_q     <= 4'd0;
      gray_q     <= 4'd0;
      stab_cnt_q <= '0;
      bin_q      <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      upd_q      <= 1'b0;
      state_q    <= BLANK_U;
      ref_cnt_q  <= '0;
      code_q     <= 4'd0;
      en_n_q     <= 2'b11;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      gray_q     <= gray_d;
      stab_cnt_q <= stab_cnt_d;
      bin_q      <= bin_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      upd_q      <= upd_d;
      state_q    <= state_d;
      ref_cnt_q  <= ref_cnt_d;
      code_q     <= code_d;
      en_n_q     <= en_n_d;
    end
  end

  assign binary_code  = code_q;
  assign digit_en_n   = en_n_q;
  assign bin_value    = bin_q;
  assign update_pulse = upd_q;

endmodule

// File: tb/tb_gray_digit_scanner.sv
// Scoreboard bench for gray_digit_scanner: stimulus pushes expected commits,
// a negedge monitor pops them on update_pulse and checks every displayed digit.
module tb_gray_digit_scanner;
  localparam int RD = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] gray_in = 4'd0;
  logic [3:0] binary_code;
  logic [1:0] digit_en_n;
  logic [3:0] bin_value;
  logic       update_pulse;

  always #5 clk = ~clk;

  gray_digit_scanner #(.REFRESH_DIV(RD), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in),
    .binary_code(binary_code), .digit_en_n(digit_en_n),
    .bin_value(bin_value), .update_pulse(update_pulse)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  cur_u = 4'd0;
  logic [3:0]  cur_t = 4'd0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: digit display checked every cycle, commits popped on update_pulse.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n) begin
      cur_u = 4'd0;
      cur_t = 4'd0;
    end else begin
      case (digit_en_n)
        2'b10: check("units_digit", binary_code, cur_u);
        2'b01: begin
          check("tens_digit", binary_code, cur_t);
          check("tens_lit_nonzero", int'(cur_t != 4'd0), 1);
        end
        2'b11: check("blank_code", binary_code, 0);
        default: check("en_n_legal", digit_en_n, 3);
      endcase
      if (update_pulse) begin
        check("update_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bin_value", bin_value, e[11:8]);
          cur_t = e[7:4];
          cur_u = e[3:0];
        end
      end
    end
  end

  task automatic push(input logic [3:0] b, input logic [3:0] t, input logic [3:0] u);
    exp_q.push_back({b, t, u});
  endtask

  task automatic latency(input string name, input logic [3:0] g,
                         input int old_bin, input int new_bin);
    @(negedge clk);
    gray_in = g;
    repeat (5) @(negedge clk);
    check({name, "_edge5_old"}, bin_value, old_bin);
    @(negedge clk);
    check({name, "_edge6_new"}, bin_value, new_bin);
    check({name, "_pulse_hi"}, update_pulse, 1);
    @(negedge clk);
    check({name, "_pulse_1cyc"}, update_pulse, 0);
  endtask

  task automatic window(input string name, input int e10, input int e01, input int e11);
    int c10, c01, c11;
    c10 = 0; c01 = 0; c11 = 0;
    for (int i = 0; i < 2 * RD + 2; i++) begin
      @(negedge clk);
      if (digit_en_n == 2'b10) c10++;
      else if (digit_en_n == 2'b01) c01++;
      else if (digit_en_n == 2'b11) c11++;
    end
    check({name, "_units_cycles"}, c10, e10);
    check({name, "_tens_cycles"}, c01, e01);
    check({name, "_dark_cycles"}, c11, e11);
  endtask

  // Returns at the first negedge of a units slot.
  task automatic wait_slot_start(input string name);
    logic [1:0] prev;
    int k;
    bit found;
    found = 0;
    k = 0;
    while (!found && k < 40) begin
      prev = digit_en_n;
      @(negedge clk);
      k++;
      if (digit_en_n == 2'b10 && prev != 2'b10) found = 1;
    end
    check({name, "_slot_found"}, int'(found), 1);
  endtask

  task automatic period(input string name);
    logic [1:0] prev;
    int cyc;
    bit found;
    wait_slot_start(name);
    cyc = 0;
    found = 0;
    while (!found && cyc < 40) begin
      prev = digit_en_n;
      @(negedge clk);
      cyc++;
      if (digit_en_n == 2'b10 && prev != 2'b10) found = 1;
    end
    check({name, "_period"}, cyc, 2 * RD + 2);
  endtask

  initial begin
    logic [1:0] seq [6];
    int k;
    seq = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};

    // Initial reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_en_n", digit_en_n, 3);
    check("rst_code", binary_code, 0);
    check("rst_bin", bin_value, 0);
    check("rst_pulse", update_pulse, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single digit: 1101 -> 9, tens blanked
    push(4'd9, 4'd0, 4'd9);
    latency("t2", 4'b1101, 0, 9);
    window("t2", 4, 0, 6);

    // Two digits: 1000 -> 15
    push(4'd15, 4'd1, 4'd5);
    latency("t3", 4'b1000, 9, 15);
    window("t3", 4, 4, 2);
    period("t3");

    // Reset in the middle of the tens slot
    k = 0;
    while (digit_en_n != 2'b01 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t1_in_scan_t", digit_en_n, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    gray_in = 4'd0;
    #1;
    check("t1_async_en_n", digit_en_n, 3);
    check("t1_async_code", binary_code, 0);
    check("t1_async_bin", bin_value, 0);
    check("t1_async_pulse", update_pulse, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t1_edge%0d_en_n", i + 1), digit_en_n, seq[i]);
    end
    window("t1", 4, 0, 6);

    // Tens boundary: 1111 -> 10, then 0101 -> 6
    push(4'd10, 4'd1, 4'd0);
    latency("t4a", 4'b1111, 0, 10);
    window("t4a", 4, 4, 2);
    push(4'd6, 4'd0, 4'd6);
    latency("t4b", 4'b0101, 10, 6);
    repeat (2) @(negedge clk);
    window("t4b", 4, 0, 6);

    // Debounce: back to 0, toggle, then hold 0001
    push(4'd0, 4'd0, 4'd0);
    latency("t5a", 4'b0000, 6, 0);
    for (int i = 0; i < 20; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (2) @(negedge clk);
    end
    check("t5_toggle_bin", bin_value, 0);
    push(4'd1, 4'd0, 4'd1);
    latency("t5b", 4'b0001, 0, 1);

    // One-cycle glitch, then a commit landing mid units slot
    @(negedge clk);
    gray_in = 4'b0011;
    @(negedge clk);
    gray_in = 4'b0001;
    repeat (10) @(negedge clk);
    check("t6_glitch_bin", bin_value, 1);
    wait_slot_start("t6");
    repeat (5) @(negedge clk);
    push(4'd3, 4'd0, 4'd3);
    gray_in = 4'b0010;
    repeat (6) @(negedge clk);
    check("t6_pulse", update_pulse, 1);
    check("t6_old_en_n", digit_en_n, 2);
    check("t6_old_code", binary_code, 1);
    @(negedge clk);
    check("t6_new_en_n", digit_en_n, 2);
    check("t6_new_code", binary_code, 3);
    @(negedge clk);
    check("t6_slot_end_en_n", digit_en_n, 2);
    check("t6_slot_end_code", binary_code, 3);
    @(negedge clk);
    check("t6_gap_en_n", digit_en_n, 3);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
